multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences the shared MIPS datapath (PC, IM/DMem, GPR, Alu, Extender) over multiple cycles per instruction instead of one.
- Drives all datapath enables and mux selects from a registered state.
- Supports a memory ready handshake and keeps a retired-instruction counter.
- Sits between the instruction register opcode/funct fields and the datapath muxes in the multicycle core top.

Parameters:
- MEM_HANDSHAKE, 1, when 1 the memory states wait for MemRdy; when 0 MemRdy is ignored and treated as 1.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- OpCode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- Zero  in  1  Alu zero flag.
- MemRdy  in  1  memory access completes this cycle.
- PcWr  out  1  unconditional PC write.
- PcWrCond  out  1  PC write if Zero.
- IorD  out  1  memory address select: 0 = PC, 1 = Alu result register.
- MemR  out  1  memory read.
- MemW  out  1  memory write.
- IRWr  out  1  instruction register load.
- Mem2R  out  1  GPR write data from the memory data register.
- RegDst  out  1  1 = rd, 0 = rt.
- RegW  out  1  GPR write.
- AluSrcA  out  1  0 = PC, 1 = GPR A.
- AluSrcB  out  2  00 = B, 01 = constant 4, 10 = ext imm, 11 = ext imm << 2.
- AluOp  out  2  00 = add, 01 = sub, 10 = by funct, 11 = by opcode (immediate ops).
- PcSrc  out  2  00 = Alu result, 01 = AluOut register, 10 = jump target.
- ExtOp  out  2  00 = zero extend, 01 = sign extend, 10 = upper (lui).
- State  out  4  current state, for debug and display.
- Illegal  out  1  one-cycle pulse on an unknown opcode.
- InstrCnt  out  CNT_W  count of retired instructions.

Behaviour:
- States:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5.
  - EXEC = 6, ALUWB = 7, BRANCH = 8, JUMP = 9, IEXEC = 10, IWB = 11.
  - Codes 12–15 are unreachable; if entered, go to FETCH next cycle.
- Reset:
  - State = FETCH, InstrCnt = 0, Illegal = 0.
  - While Reset is high, PcWr, PcWrCond, MemW, IRWr and RegW are forced to 0.
- FETCH:
  - Asserts MemR, IorD = 0, AluSrcA = 0, AluSrcB = 01, AluOp = 00, PcSrc = 00.
  - Asserts IRWr and PcWr only in the cycle MemRdy = 1, then goes to DECODE.
  - Otherwise holds FETCH with IRWr = PcWr = 0.
- DECODE:
  - AluSrcA = 0, AluSrcB = 11, AluOp = 00, ExtOp = 01 (branch target precompute).
  - Next state by OpCode:
    - 100011 / 101011 -> MEMADR.
    - 000000 -> EXEC.
    - 000100 -> BRANCH.
    - 000010 -> JUMP.
    - 001000 / 001101 / 001111 -> IEXEC.
    - Any other opcode -> FETCH with Illegal = 1 for one cycle; InstrCnt does not increment.
- MEMADR: AluSrcA = 1, AluSrcB = 10, ExtOp = 01, AluOp = 00. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: MemR = 1, IorD = 1. Holds until MemRdy, then goes to MEMWB.
- MEMWB: RegW = 1, Mem2R = 1, RegDst = 0; next FETCH.
- MEMWR: MemW = 1, IorD = 1. Holds until MemRdy, then goes to FETCH.
  - MemW stays high for every wait cycle; the memory commits on the MemRdy cycle.
- EXEC: AluSrcA = 1, AluSrcB = 00, AluOp = 10; next ALUWB.
- ALUWB: RegW = 1, RegDst = 1, Mem2R = 0; next FETCH.
- BRANCH:
  - AluSrcA = 1, AluSrcB = 00, AluOp = 01, PcWrCond = 1, PcSrc = 01; next FETCH.
  - The PC is written only when Zero = 1.
- JUMP: PcWr = 1, PcSrc = 10; next FETCH.
- IEXEC:
  - AluSrcA = 1, AluSrcB = 10, AluOp = 11.
  - ExtOp = 01 for addi, 00 for ori, 10 for lui. Next IWB.
- IWB: RegW = 1, RegDst = 0, ExtOp held from IEXEC; next FETCH.
- Unlisted outputs are 0 in every state.
- InstrCnt increments by 1, wrapping modulo 2^CNT_W, on the final-state edge of:
  - MEMWB, ALUWB, BRANCH, JUMP and IWB;
  - MEMWR, only on its MemRdy cycle.
- Instruction cycle counts with MemRdy held at 1: lw 5, sw 4, R-type 4, addi/ori/lui 4, beq 3, j 3.
- funct is not decoded here; it passes to the Alu control via AluOp = 10.
- Reset asserted mid-instruction: the next state is FETCH. No partial RegW/MemW occurs in the Reset cycle because those outputs are masked.

Test Plan:
- Reset, then MemRdy = 1 with lw (0x8C010004) -> State sequence 0,1,2,3,4,0; RegW = 1 and Mem2R = 1 only in state 4; InstrCnt = 1.
- sw (0xAC010008) with MemRdy low for 3 cycles in MEMWR -> MemW high for 4 cycles, then FETCH; InstrCnt increments once.
- beq (0x10220003) with Zero = 1, then repeated with Zero = 0 -> PcWrCond = 1 in state 8 both times; 3 cycles each.
- ori (0x34220055) -> ExtOp = 00 in states 10 and 11; lui (0x3C021234) -> ExtOp = 10; RegDst = 0 on the write.
- OpCode 111111 -> Illegal pulses one cycle after DECODE; State returns to 0; InstrCnt unchanged.
- Reset asserted during MEMRD -> next cycle State = 0, RegW = MemW = 0, InstrCnt = 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: Moore outputs decoded from the registered state; lw 5, sw/R/imm 4, beq/j 3 cycles.
// Memory states stall on MemRdy (ignored when MEM_HANDSHAKE=0); InstrCnt counts retirements, Illegal pulses after DECODE.
module multicycle_ctrl #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       funct,
    input  logic             Zero,
    input  logic             MemRdy,
    output logic             PcWr,
    output logic             PcWrCond,
    output logic             IorD,
    output logic             MemR,
    output logic             MemW,
    output logic             IRWr,
    output logic             Mem2R,
    output logic             RegDst,
    output logic             RegW,
    output logic             AluSrcA,
    output logic [1:0]       AluSrcB,
    output logic [1:0]       AluOp,
    output logic [1:0]       PcSrc,
    output logic [1:0]       ExtOp,
    output logic [3:0]       State,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstrCnt
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IEXEC  = 4'd10, S_IWB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [1:0]       imm_ext_q, imm_ext_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_rdy;
    logic             retire;

    // funct is decoded by the Alu control; Zero gates the PC write in the datapath
    logic unused_inputs;
    assign unused_inputs = ^{funct, Zero};

    assign mem_rdy = MEM_HANDSHAKE ? MemRdy : 1'b1;

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        imm_ext_d = imm_ext_q;
        retire    = 1'b0;
        PcWr      = 1'b0;
        PcWrCond  = 1'b0;
        IorD      = 1'b0;
        MemR      = 1'b0;
        MemW      = 1'b0;
        IRWr      = 1'b0;
        Mem2R     = 1'b0;
        RegDst    = 1'b0;
        RegW      = 1'b0;
        AluSrcA   = 1'b0;
        AluSrcB   = 2'b00;
        AluOp     = 2'b00;
        PcSrc     = 2'b00;
        ExtOp     = 2'b00;

        case (state_q)
            S_FETCH: begin
                MemR    = 1'b1;
                AluSrcB = 2'b01;
                if (mem_rdy) begin
                    IRWr    = 1'b1;
                    PcWr    = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                AluSrcB = 2'b11;
                ExtOp   = 2'b01;
                case (OpCode)
                    OP_LW, OP_SW:            state_d = S_MEMADR;
                    OP_RTYPE:                state_d = S_EXEC;
                    OP_BEQ:                  state_d = S_BRANCH;
                    OP_J:                    state_d = S_JUMP;
                    OP_ADDI, OP_ORI, OP_LUI: state_d = S_IEXEC;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                AluSrcA = 1'b1;
                AluSrcB = 2'b10;
                ExtOp   = 2'b01;
                state_d = (OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemR = 1'b1;
                IorD = 1'b1;
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegW    = 1'b1;
                Mem2R   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                MemW = 1'b1;
                IorD = 1'b1;
                if (mem_rdy) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                AluSrcA = 1'b1;
                AluOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegW    = 1'b1;
                RegDst  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                AluSrcA  = 1'b1;
                AluOp    = 2'b01;
                PcWrCond = 1'b1;
                PcSrc    = 2'b01;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PcWr    = 1'b1;
                PcSrc   = 2'b10;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_IEXEC: begin
                AluSrcA = 1'b1;
                AluSrcB = 2'b10;
                AluOp   = 2'b11;
                case (OpCode)
                    OP_ORI:  imm_ext_d = 2'b00;
                    OP_LUI:  imm_ext_d = 2'b10;
                    default: imm_ext_d = 2'b01;
                endcase
                ExtOp   = imm_ext_d;
                state_d = S_IWB;
            end
            S_IWB: begin
                // IR may already be changing upstream, so the extender mode comes from IEXEC's capture
                RegW    = 1'b1;
                ExtOp   = imm_ext_q;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

        if (Reset) begin
            PcWr     = 1'b0;
            PcWrCond = 1'b0;
            MemW     = 1'b0;
            IRWr     = 1'b0;
            RegW     = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            imm_ext_q <= 2'b00;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            imm_ext_q <= imm_ext_d;
            cnt_q     <= cnt_d;
        end
    end

    assign State    = state_q;
    assign Illegal  = illegal_q;
    assign InstrCnt = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through its state sequence.
module tb_multicycle_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [5:0]  OpCode = '0;
    logic [5:0]  funct = '0;
    logic        Zero = 1'b0;
    logic        MemRdy = 1'b0;
    logic        PcWr, PcWrCond, IorD, MemR, MemW, IRWr, Mem2R, RegDst, RegW, AluSrcA;
    logic [1:0]  AluSrcB, AluOp, PcSrc, ExtOp;
    logic [3:0]  State;
    logic        Illegal;
    logic [31:0] InstrCnt;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_cnt = '0;

    multicycle_ctrl #(.MEM_HANDSHAKE(1'b1), .CNT_W(32)) dut (
        .Clk(Clk), .Reset(Reset), .OpCode(OpCode), .funct(funct), .Zero(Zero), .MemRdy(MemRdy),
        .PcWr(PcWr), .PcWrCond(PcWrCond), .IorD(IorD), .MemR(MemR), .MemW(MemW), .IRWr(IRWr),
        .Mem2R(Mem2R), .RegDst(RegDst), .RegW(RegW), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB),
        .AluOp(AluOp), .PcSrc(PcSrc), .ExtOp(ExtOp), .State(State), .Illegal(Illegal),
        .InstrCnt(InstrCnt)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_ir(input logic [31:0] ir);
        OpCode = ir[31:26];
        funct  = ir[5:0];
    endtask

    task automatic test_reset();
        set_ir(32'h8C010004);
        MemRdy = 1'b1;
        step();
        step();
        checks++; if (State !== 4'd0) begin errors++; $display("FAIL reset_state actual=%0d required=0", State); end
        checks++; if (InstrCnt !== 32'd0) begin errors++; $display("FAIL reset_cnt actual=%0d required=0", InstrCnt); end
        checks++; if (Illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal actual=%b required=0", Illegal); end
        checks++; if ({PcWr, IRWr, RegW, MemW, PcWrCond} !== 5'b0) begin
            errors++; $display("FAIL reset_mask actual=%b required=00000", {PcWr, IRWr, RegW, MemW, PcWrCond});
        end
        Reset = 1'b0;
        #1;
        checks++; if ({IRWr, PcWr, MemR} !== 3'b111) begin
            errors++; $display("FAIL fetch_unmasked actual=%b required=111", {IRWr, PcWr, MemR});
        end
    endtask

    task automatic test_lw();
        int exp_st [6] = '{0, 1, 2, 3, 4, 0};
        set_ir(32'h8C010004);
        MemRdy = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++; if (State !== 4'(exp_st[i])) begin errors++; $display("FAIL lw_state[%0d] actual=%0d required=%0d", i, State, exp_st[i]); end
            checks++; if ({RegW, Mem2R} !== ((exp_st[i] == 4) ? 2'b11 : 2'b00)) begin
                errors++; $display("FAIL lw_regw_mem2r[%0d] actual=%b required=%b", i, {RegW, Mem2R}, (exp_st[i] == 4) ? 2'b11 : 2'b00);
            end
            if (i < 5) step();
        end
        exp_cnt++;
        checks++; if (InstrCnt !== exp_cnt) begin errors++; $display("FAIL lw_cnt actual=%0d required=%0d", InstrCnt, exp_cnt); end
    endtask

    task automatic test_sw_wait();
        int memw_cycles = 0;
        set_ir(32'hAC010008);
        MemRdy = 1'b1;
        step();
        step();
        MemRdy = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin MemRdy = 1'b1; #1; end
            checks++; if (State !== 4'd5) begin errors++; $display("FAIL sw_state[%0d] actual=%0d required=5", i, State); end
            checks++; if (InstrCnt !== exp_cnt) begin errors++; $display("FAIL sw_cnt_hold[%0d] actual=%0d required=%0d", i, InstrCnt, exp_cnt); end
            if (MemW === 1'b1 && IorD === 1'b1) memw_cycles++;
            step();
        end
        exp_cnt++;
        checks++; if (memw_cycles != 4) begin errors++; $display("FAIL sw_memw_cycles actual=%0d required=4", memw_cycles); end
        checks++; if (State !== 4'd0 || MemW !== 1'b0) begin errors++; $display("FAIL sw_end actual=%0d/%b required=0/0", State, MemW); end
        checks++; if (InstrCnt !== exp_cnt) begin errors++; $display("FAIL sw_cnt actual=%0d required=%0d", InstrCnt, exp_cnt); end
    endtask

    task automatic test_beq();
        set_ir(32'h10220003);
        MemRdy = 1'b1;
        for (int z = 1; z >= 0; z--) begin
            Zero = z[0];
            step();
            step();
            checks++; if ({State, PcWrCond, PcSrc, AluOp} !== {4'd8, 1'b1, 2'b01, 2'b01}) begin
                errors++; $display("FAIL beq_z%0d_branch actual=%h required=%h", z, {State, PcWrCond, PcSrc, AluOp}, {4'd8, 1'b1, 2'b01, 2'b01});
            end
            step();
            exp_cnt++;
            checks++; if (State !== 4'd0 || InstrCnt !== exp_cnt) begin
                errors++; $display("FAIL beq_z%0d_end actual=%0d/%0d required=0/%0d", z, State, InstrCnt, exp_cnt);
            end
        end
        Zero = 1'b0;
    endtask

    task automatic test_imm();
        logic [31:0] irs  [2] = '{32'h34220055, 32'h3C021234};
        logic [1:0]  exts [2] = '{2'b00, 2'b10};
        MemRdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_ir(irs[i]);
            step();
            step();
            checks++; if (State !== 4'd10 || ExtOp !== exts[i] || AluOp !== 2'b11) begin
                errors++; $display("FAIL imm%0d_iexec actual=%0d/%b/%b required=10/%b/11", i, State, ExtOp, AluOp, exts[i]);
            end
            step();
            OpCode = 6'b001000;
            #1;
            checks++; if ({State, ExtOp, RegDst, RegW} !== {4'd11, exts[i], 1'b0, 1'b1}) begin
                errors++; $display("FAIL imm%0d_iwb actual=%b required=%b", i, {State, ExtOp, RegDst, RegW}, {4'd11, exts[i], 1'b0, 1'b1});
            end
            step();
            exp_cnt++;
            checks++; if (State !== 4'd0 || InstrCnt !== exp_cnt) begin
                errors++; $display("FAIL imm%0d_end actual=%0d/%0d required=0/%0d", i, State, InstrCnt, exp_cnt);
            end
        end
    endtask

    task automatic test_rtype_jump();
        MemRdy = 1'b1;
        set_ir(32'h00221820);
        step();
        step();
        checks++; if ({State, AluSrcA, AluSrcB, AluOp} !== {4'd6, 1'b1, 2'b00, 2'b10}) begin
            errors++; $display("FAIL rtype_exec actual=%b required=%b", {State, AluSrcA, AluSrcB, AluOp}, {4'd6, 1'b1, 2'b00, 2'b10});
        end
        step();
        checks++; if ({State, RegW, RegDst, Mem2R} !== {4'd7, 1'b1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL rtype_wb actual=%b required=%b", {State, RegW, RegDst, Mem2R}, {4'd7, 1'b1, 1'b1, 1'b0});
        end
        step();
        exp_cnt++;
        set_ir(32'h08000010);
        step();
        step();
        checks++; if ({State, PcWr, PcSrc} !== {4'd9, 1'b1, 2'b10}) begin
            errors++; $display("FAIL jump actual=%b required=%b", {State, PcWr, PcSrc}, {4'd9, 1'b1, 2'b10});
        end
        step();
        exp_cnt++;
        checks++; if (State !== 4'd0 || InstrCnt !== exp_cnt) begin
            errors++; $display("FAIL rj_end actual=%0d/%0d required=0/%0d", State, InstrCnt, exp_cnt);
        end
    endtask

    task automatic test_illegal();
        MemRdy = 1'b1;
        OpCode = 6'b111111;
        step();
        checks++; if (State !== 4'd1 || Illegal !== 1'b0) begin
            errors++; $display("FAIL ill_decode actual=%0d/%b required=1/0", State, Illegal);
        end
        step();
        checks++; if (State !== 4'd0 || Illegal !== 1'b1) begin
            errors++; $display("FAIL ill_pulse actual=%0d/%b required=0/1", State, Illegal);
        end
        MemRdy = 1'b0;
        step();
        checks++; if (Illegal !== 1'b0 || State !== 4'd0) begin
            errors++; $display("FAIL ill_clear actual=%0d/%b required=0/0", State, Illegal);
        end
        checks++; if (InstrCnt !== exp_cnt) begin errors++; $display("FAIL ill_cnt actual=%0d required=%0d", InstrCnt, exp_cnt); end
    endtask

    task automatic test_reset_midinstr();
        set_ir(32'h8C010004);
        MemRdy = 1'b1;
        step();
        step();
        MemRdy = 1'b0;
        step();
        checks++; if (State !== 4'd3) begin errors++; $display("FAIL mid_memrd actual=%0d required=3", State); end
        Reset  = 1'b1;
        MemRdy = 1'b1;
        step();
        checks++; if ({State, RegW, MemW, IRWr, PcWr} !== {4'd0, 4'b0000}) begin
            errors++; $display("FAIL mid_reset actual=%b required=%b", {State, RegW, MemW, IRWr, PcWr}, {4'd0, 4'b0000});
        end
        checks++; if (InstrCnt !== 32'd0) begin errors++; $display("FAIL mid_cnt actual=%0d required=0", InstrCnt); end
        Reset = 1'b0;
        exp_cnt = '0;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_beq();
        test_imm();
        test_rtype_jump();
        test_illegal();
        test_reset_midinstr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
